// File: rtl/sr_register_bank.sv
// rtl/sr_register_bank.sv - bank of clocked SR cells with edge pulses and conflict tracking
module sr_register_bank #(
   parameter int                 WIDTH         = 8,
   parameter int                 CONFLICT_MODE = 0,
   parameter logic [WIDTH-1:0]   RESET_VALUE   = {WIDTH{1'b0}},
   parameter int                 CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall,
   output logic [WIDTH-1:0] conflict_flag,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] flag_q, flag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] conflict;
   logic             hit;

   // Next state of every cell; with en low the cell simply holds, so pulses fall out as zero
   always_comb begin
      conflict = {WIDTH{en}} & s & r;
      hit      = |conflict;
      q_d      = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (en) begin
            case ({s[i], r[i]})
               2'b01:   q_d[i] = 1'b0;
               2'b10:   q_d[i] = 1'b1;
               2'b11: begin
                  // Unlisted policy values fall back to hold
                  case (CONFLICT_MODE)
                     1:       q_d[i] = 1'b1;
                     2:       q_d[i] = 1'b0;
                     3:       q_d[i] = ~q_q[i];
                     default: q_d[i] = q_q[i];
                  endcase
               end
               default: q_d[i] = q_q[i];
            endcase
         end
      end
      rise_d = q_d & ~q_q;
      fall_d = ~q_d & q_q;
   end

   // Sticky flags and saturating counter; a conflict on the clearing edge survives the clear
   always_comb begin
      flag_d = (clr_flag ? {WIDTH{1'b0}} : flag_q) | conflict;
      cnt_d  = cnt_q;
      if (clr_flag) begin
         cnt_d = hit ? CNT_ONE : {CNT_W{1'b0}};
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State registers; reset wipes state and any pending pulses immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= RESET_VALUE;
         rise_q <= '0;
         fall_q <= '0;
         flag_q <= '0;
         cnt_q  <= '0;
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q             = q_q;
   assign q_rise        = rise_q;
   assign q_fall        = fall_q;
   assign conflict_flag = flag_q;
   assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_sr_register_bank.sv
// tb/tb_sr_register_bank.sv - bench for sr_register_bank across all conflict policies
module tb_sr_register_bank;

   localparam int W  = 4;
   localparam int CW = 3;
   localparam int NI = 5;
   localparam logic [W-1:0] RV = 4'b1010;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [W-1:0]  s;
   logic [W-1:0]  r;
   logic          clr_flag;

   logic [NI-1:0][W-1:0]  q_o;
   logic [NI-1:0][W-1:0]  rise_o;
   logic [NI-1:0][W-1:0]  fall_o;
   logic [NI-1:0][W-1:0]  flag_o;
   logic [NI-1:0][CW-1:0] cnt_o;

   int modes [NI] = '{0, 1, 2, 3, 5};

   // Reference model state
   logic [W-1:0] mq [NI];
   logic [W-1:0] mr [NI];
   logic [W-1:0] mf [NI];
   logic [W-1:0] mfl [NI];
   int           mc [NI];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int MODE = (g == 4) ? 5 : g;
      sr_register_bank #(
         .WIDTH(W), .CONFLICT_MODE(MODE), .RESET_VALUE(RV), .CNT_W(CW)
      ) dut (
         .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
         .q(q_o[g]), .q_rise(rise_o[g]), .q_fall(fall_o[g]),
         .conflict_flag(flag_o[g]), .conflict_cnt(cnt_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mq[i] = RV; mr[i] = '0; mf[i] = '0; mfl[i] = '0; mc[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         int em;
         bit any;
         logic [W-1:0] nq;
         em  = (modes[i] >= 0 && modes[i] <= 3) ? modes[i] : 0;
         any = 0;
         nq  = mq[i];
         if (clr_flag) mfl[i] = '0;
         for (int ch = 0; ch < W; ch++) begin
            if (en) begin
               if (s[ch] && !r[ch]) nq[ch] = 1'b1;
               else if (!s[ch] && r[ch]) nq[ch] = 1'b0;
               else if (s[ch] && r[ch]) begin
                  any = 1;
                  mfl[i][ch] = 1'b1;
                  if (em == 1) nq[ch] = 1'b1;
                  else if (em == 2) nq[ch] = 1'b0;
                  else if (em == 3) nq[ch] = !mq[i][ch];
               end
            end
         end
         for (int ch = 0; ch < W; ch++) begin
            mr[i][ch] = nq[ch] && !mq[i][ch];
            mf[i][ch] = !nq[ch] && mq[i][ch];
         end
         mq[i] = nq;
         if (clr_flag) mc[i] = any ? 1 : 0;
         else if (any) mc[i] = (mc[i] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mc[i] + 1;
      end
   endtask

   task automatic check_all(input string ph);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s q[%0d]", ph, i),    32'(q_o[i]),    32'(mq[i]));
         chk($sformatf("%s rise[%0d]", ph, i), 32'(rise_o[i]), 32'(mr[i]));
         chk($sformatf("%s fall[%0d]", ph, i), 32'(fall_o[i]), 32'(mf[i]));
         chk($sformatf("%s flag[%0d]", ph, i), 32'(flag_o[i]), 32'(mfl[i]));
         chk($sformatf("%s cnt[%0d]", ph, i),  32'(cnt_o[i]),  32'(mc[i]));
      end
   endtask

   task automatic step(input string ph, input logic e, input logic [W-1:0] ss,
                       input logic [W-1:0] rr, input logic c);
      en = e; s = ss; r = rr; clr_flag = c;
      @(posedge clk);
      model_step();
      #1;
      check_all(ph);
   endtask

   // Called just after an edge: pulse reset low between edges and check its immediate effect
   task automatic async_reset(input string ph);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all(ph);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; s = '0; r = '0; clr_flag = 1'b0;
      #12 rst_n = 1'b0;
      #1 model_reset();
      check_all("reset");
      chk("reset q const", 32'(q_o[3]), 32'(RV));
      #1 rst_n = 1'b1;

      for (int k = 0; k < 3; k++) step("en0 hold", 1'b0, 4'b1111, 4'b0000, 1'b0);
      chk("en0 q const", 32'(q_o[0]), 32'(RV));

      step("set", 1'b1, 4'b0101, 4'b0000, 1'b0);
      chk("set q const", 32'(q_o[0]), 32'h0000000f);
      chk("set rise const", 32'(rise_o[0]), 32'h00000005);
      step("idle", 1'b1, 4'b0000, 4'b0000, 1'b0);
      step("reset bits", 1'b1, 4'b0000, 4'b0011, 1'b0);
      chk("rst q const", 32'(q_o[0]), 32'h0000000c);
      chk("rst fall const", 32'(fall_o[0]), 32'h00000003);

      step("conf1", 1'b1, 4'b0001, 4'b0001, 1'b0);
      chk("toggle rise const", 32'(rise_o[3]), 32'h00000001);
      step("conf2", 1'b1, 4'b0001, 4'b0001, 1'b0);
      chk("toggle fall const", 32'(fall_o[3]), 32'h00000001);
      chk("mode1 q const", 32'(q_o[1]), 32'h0000000d);
      chk("mode2 q const", 32'(q_o[2]), 32'h0000000c);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("conf cnt const[%0d]", i), 32'(cnt_o[i]), 32'd2);
         chk($sformatf("conf flag const[%0d]", i), 32'(flag_o[i]), 32'h00000001);
      end

      for (int k = 0; k < 10; k++) step("sat", 1'b1, 4'b1111, 4'b1111, 1'b0);
      for (int i = 0; i < NI; i++) chk($sformatf("sat cnt const[%0d]", i), 32'(cnt_o[i]), 32'd7);

      step("clr", 1'b1, 4'b0000, 4'b0000, 1'b1);
      for (int k = 0; k < 5; k++) step("build5", 1'b1, 4'b1111, 4'b1111, 1'b0);
      chk("build cnt const", 32'(cnt_o[0]), 32'd5);
      step("clr noconf", 1'b1, 4'b0000, 4'b0000, 1'b1);
      chk("clr cnt const", 32'(cnt_o[2]), 32'd0);
      chk("clr flag const", 32'(flag_o[2]), 32'd0);
      for (int k = 0; k < 5; k++) step("build5b", 1'b1, 4'b1111, 4'b1111, 1'b0);
      step("clr race", 1'b1, 4'b0100, 4'b0100, 1'b1);
      chk("race flag const", 32'(flag_o[1]), 32'h00000004);
      chk("race cnt const", 32'(cnt_o[1]), 32'd1);
      step("clr en0", 1'b0, 4'b1111, 4'b1111, 1'b1);
      chk("clr en0 flag const", 32'(flag_o[3]), 32'd0);
      chk("clr en0 cnt const", 32'(cnt_o[3]), 32'd0);

      for (int k = 0; k < 3; k++) step("toggling", 1'b1, 4'b0001, 4'b0001, 1'b0);
      async_reset("midop reset");
      chk("midop q const", 32'(q_o[3]), 32'(RV));
      chk("midop cnt const", 32'(cnt_o[3]), 32'd0);
      step("after reset", 1'b1, 4'b0001, 4'b0001, 1'b0);
      chk("after reset q const", 32'(q_o[3]), 32'h0000000b);
      chk("after reset cnt const", 32'(cnt_o[3]), 32'd1);

      for (int k = 0; k < 300; k++) begin
         step("rand", ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 9) == 0));
         if (k % 97 == 50) async_reset("rand reset");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
